// File: rtl/divisor_scan_displays_pkg.sv
// Shared display constants and the digit-index width helper used by the
// divider top, the scan ring and the bus interface.
package divisor_scan_displays_pkg;

  localparam int BOARD_DEFAULT_DIV = 99999;  // 100 MHz board -> 1 kHz scan tick
  localparam int BOARD_N_DIGITS    = 4;

  function automatic int clog2_fn(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/divisor_scan_displays_if.sv
// Control and display-side signals of the programmable scan divider.
interface divisor_scan_displays_if
  import divisor_scan_displays_pkg::*;
#(
  parameter int CNT_W    = 17,
  parameter int N_DIGITS = BOARD_N_DIGITS,
  parameter int DIG_W    = clog2_fn(N_DIGITS)
);
  logic                en;
  logic                div_load;
  logic [CNT_W-1:0]    div_val;
  logic                clk_out;
  logic                tick;
  logic [DIG_W-1:0]    digit_idx;
  logic [N_DIGITS-1:0] digit_sel_n;
  logic                scan_wrap;

  modport master (
    output en, div_load, div_val,
    input  clk_out, tick, digit_idx, digit_sel_n, scan_wrap
  );

  modport slave (
    input  en, div_load, div_val,
    output clk_out, tick, digit_idx, digit_sel_n, scan_wrap
  );
endinterface

// File: rtl/divisor_scan_displays_scan_ring.sv
// Digit-scan counter with registered active-low one-hot anode decode.
module scan_ring #(
  parameter int N_DIGITS = 4,
  parameter int DIG_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adv,
  output logic [DIG_W-1:0]    digit_idx,
  output logic [N_DIGITS-1:0] digit_sel_n,
  output logic                scan_wrap
);

  localparam logic [DIG_W-1:0] LAST_IDX = DIG_W'(N_DIGITS - 1);

  logic [DIG_W-1:0]    idx_q, idx_d;
  logic [N_DIGITS-1:0] sel_n_q, sel_n_d;
  logic                wrap_q, wrap_d;

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (adv) begin
      if (idx_q == LAST_IDX) begin
        idx_d  = '0;
        wrap_d = 1'b1;
      end else begin
        idx_d = idx_q + DIG_W'(1);
      end
    end
  end

  // Decode from the next index so the anode select moves on the same edge.
  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_sel
      assign sel_n_d[gi] = (idx_d != DIG_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q   <= '0;
      sel_n_q <= ~N_DIGITS'(1);
      wrap_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      sel_n_q <= sel_n_d;
      wrap_q  <= wrap_d;
    end
  end

  assign digit_idx   = idx_q;
  assign digit_sel_n = sel_n_q;
  assign scan_wrap   = wrap_q;

endmodule

// File: rtl/divisor_scan_displays.sv
// Runtime-programmable clock divider producing a square clock, a one-cycle
// tick and a multiplexed-display digit scan driven by that tick.
module divisor_scan_displays
  import divisor_scan_displays_pkg::*;
#(
  parameter int CNT_W       = 17,
  parameter int DEFAULT_DIV = BOARD_DEFAULT_DIV,
  parameter int N_DIGITS    = BOARD_N_DIGITS,
  parameter int DIG_W       = clog2_fn(N_DIGITS)
) (
  input logic clk,
  input logic rst,
  divisor_scan_displays_if.slave bus
);

  logic [CNT_W-1:0]    counter_q, counter_d;
  logic [CNT_W-1:0]    div_reg_q, div_reg_d;
  logic                clk_out_q, clk_out_d;
  logic                tick_q, tick_d;
  logic                adv;
  logic [DIG_W-1:0]    ring_idx;
  logic [N_DIGITS-1:0] ring_sel_n;
  logic                ring_wrap;

  // A load restarts the period and suppresses any terminal count on that edge.
  always_comb begin
    counter_d = counter_q;
    div_reg_d = div_reg_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    adv       = 1'b0;
    if (bus.div_load) begin
      div_reg_d = bus.div_val;
      counter_d = '0;
    end else if (bus.en) begin
      if (counter_q == div_reg_q) begin
        counter_d = '0;
        clk_out_d = ~clk_out_q;
        tick_d    = 1'b1;
        adv       = 1'b1;
      end else begin
        counter_d = counter_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter_q <= '0;
      div_reg_q <= CNT_W'(DEFAULT_DIV);
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      div_reg_q <= div_reg_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  scan_ring #(
    .N_DIGITS (N_DIGITS),
    .DIG_W    (DIG_W)
  ) u_scan_ring (
    .clk         (clk),
    .rst         (rst),
    .adv         (adv),
    .digit_idx   (ring_idx),
    .digit_sel_n (ring_sel_n),
    .scan_wrap   (ring_wrap)
  );

  assign bus.clk_out     = clk_out_q;
  assign bus.tick        = tick_q;
  assign bus.digit_idx   = ring_idx;
  assign bus.digit_sel_n = ring_sel_n;
  assign bus.scan_wrap   = ring_wrap;

endmodule

// File: tb/tb_divisor_scan_displays.sv
// Directed and randomized checks of the scan divider against a period/tick-count model.
module tb_divisor_scan_displays;

  localparam int CNT_W = 17;
  localparam int DEF   = 4;
  localparam int ND    = 4;
  localparam int DW    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divisor_scan_displays_if #(.CNT_W(CNT_W), .N_DIGITS(ND), .DIG_W(DW)) bus ();

  divisor_scan_displays #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF),
    .N_DIGITS    (ND)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  // Model: period length, enabled cycles elapsed in the current period, total ticks.
  int period, phase, k;
  bit m_tick, m_wrap;
  int compared = 0;
  int mismatched = 0;

  task automatic model_reset();
    period = DEF + 1;
    phase  = 0;
    k      = 0;
    m_tick = 0;
    m_wrap = 0;
  endtask

  task automatic check(input string tag);
    logic [ND-1:0] exp_sel;
    logic [DW-1:0] exp_idx;
    exp_idx = DW'(k % ND);
    exp_sel = ~(ND'(1) << (k % ND));
    compared++;
    assert (bus.tick === m_tick) else begin
      mismatched++; $error("FAIL %s tick observed=%0b expected=%0b", tag, bus.tick, m_tick);
    end
    compared++;
    assert (bus.clk_out === 1'(k % 2)) else begin
      mismatched++; $error("FAIL %s clk_out observed=%0b expected=%0b", tag, bus.clk_out, k % 2);
    end
    compared++;
    assert (bus.digit_idx === exp_idx) else begin
      mismatched++; $error("FAIL %s digit_idx observed=%0d expected=%0d", tag, bus.digit_idx, exp_idx);
    end
    compared++;
    assert (bus.digit_sel_n === exp_sel) else begin
      mismatched++; $error("FAIL %s digit_sel_n observed=%b expected=%b", tag, bus.digit_sel_n, exp_sel);
    end
    compared++;
    assert (bus.scan_wrap === m_wrap) else begin
      mismatched++; $error("FAIL %s scan_wrap observed=%0b expected=%0b", tag, bus.scan_wrap, m_wrap);
    end
  endtask

  // One clock: drive inputs, take the edge, advance the model, check #1 later.
  task automatic cyc(input bit e, input bit l, input int v, input string tag);
    bus.en       = e;
    bus.div_load = l;
    bus.div_val  = CNT_W'(v);
    @(posedge clk);
    if (l) begin
      period = v + 1;
      phase  = 0;
      m_tick = 0;
      m_wrap = 0;
    end else if (e) begin
      phase++;
      if (phase == period) begin
        phase  = 0;
        k++;
        m_tick = 1;
        m_wrap = (k % ND == 0);
      end else begin
        m_tick = 0;
        m_wrap = 0;
      end
    end else begin
      m_tick = 0;
      m_wrap = 0;
    end
    #1;
    check(tag);
  endtask

  initial begin
    int nt, n;
    bus.en = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val = '0;
    model_reset();

    // 1: reset values, first tick 5 cycles after release
    #12;
    check("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 2: free run, 8 ticks in 40 cycles
    nt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 0, "free_run");
      if (bus.tick) nt++;
    end
    compared++;
    assert (nt == 8) else begin
      mismatched++; $error("FAIL tick_count observed=%0d expected=8", nt);
    end

    // 3: load 2 mid-count, then load 0
    cyc(1, 0, 0, "pre_load");
    cyc(1, 0, 0, "pre_load");
    cyc(1, 1, 2, "load2");
    n = 0;
    do begin cyc(1, 0, 0, "after_load2"); n++; end while (!bus.tick && n < 10);
    compared++;
    assert (n == 3) else begin
      mismatched++; $error("FAIL load2_latency observed=%0d expected=3", n);
    end
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, "period3");
    cyc(1, 1, 0, "load0");
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, "div0");

    // 4: hold with en=0 at counter=2, resume
    cyc(1, 1, 4, "load4");
    cyc(1, 0, 0, "to_cnt2");
    cyc(1, 0, 0, "to_cnt2");
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, "en_low");
    n = 0;
    do begin cyc(1, 0, 0, "resume"); n++; end while (!bus.tick && n < 10);
    compared++;
    assert (n == 3) else begin
      mismatched++; $error("FAIL resume_latency observed=%0d expected=3", n);
    end

    // 5: load collides with terminal count
    n = 0;
    while (phase != period - 1 && n < 20) begin cyc(1, 0, 0, "to_term"); n++; end
    cyc(1, 1, 3, "load_at_term");
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, "after_collision");

    // random traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      cyc(r < 80, r >= 95, int'($urandom_range(0, 6)), "random");
    end

    // 6: asynchronous reset while digit_idx=3 and clk_out=1
    cyc(1, 1, 1, "load1");
    n = 0;
    while (!((k % ND == 3) && (k % 2 == 1)) && n < 100) begin cyc(1, 0, 0, "to_digit3"); n++; end
    compared++;
    assert (n < 100) else begin
      mismatched++; $error("FAIL reach_digit3 observed=timeout expected=reached");
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset");
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/divisor_scan_displays.md
Name: divisor_scan_displays

Overview:
Parametrised successor to the fixed 7-segment clock divider. It generates a divided square clock and a one-cycle tick at a runtime-programmable rate. The same tick drives a digit-scan counter for N multiplexed displays. It sits between the board clock and the display multiplexer, replacing the hard-coded divide-by-200000 path with a loadable divisor, an enable input and a digit-select output.

Parameters:
CNT_W, 17, width of the divide counter and the divisor register
DEFAULT_DIV, 99999, terminal count loaded at reset (period = DEFAULT_DIV+1 clk cycles)
N_DIGITS, 4, number of multiplexed display digits (at least 2)
DIG_W, clog2(N_DIGITS), width of the digit index (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
en  in  1  count enable; when low, all state holds
div_load  in  1  single-cycle strobe: capture div_val as the new terminal count
div_val  in  CNT_W  new terminal count; period = div_val+1
clk_out  out  1  divided square clock, toggles on each terminal count
tick  out  1  one-clk pulse per divided period
digit_idx  out  DIG_W  current digit index, 0..N_DIGITS-1
digit_sel_n  out  N_DIGITS  active-low one-hot anode select; bit digit_idx is low
scan_wrap  out  1  one-clk pulse when digit_idx wraps from N_DIGITS-1 to 0

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - counter=0, div_reg=DEFAULT_DIV
  - clk_out=0, tick=0, scan_wrap=0
  - digit_idx=0, digit_sel_n = all ones except bit0=0
- All outputs are registered; no combinational path from any input to any output.
- Normal count (en=1, div_load=0):
  - If counter != div_reg, then counter <= counter+1.
  - If counter == div_reg:
    - counter <= 0, clk_out <= ~clk_out, tick <= 1 for the next cycle.
    - digit_idx <= (digit_idx==N_DIGITS-1) ? 0 : digit_idx+1, and digit_sel_n follows in the same edge.
    - scan_wrap <= 1 on the wrap edge only.
- Cadence: tick is high exactly 1 cycle in every div_reg+1 cycles. clk_out period is 2*(div_reg+1) cycles, 50% duty.
- The tick and scan_wrap registers default to 0 on every edge where they are not set.
- div_reg == 0:
  - tick stays high continuously.
  - clk_out toggles every cycle.
  - digit_idx advances every cycle.
- div_load=1 (sampled regardless of en):
  - div_reg <= div_val and counter <= 0.
  - No tick that edge; clk_out and digit_idx unchanged.
  - The first tick after load occurs div_val+1 cycles later.
- Simultaneous div_load and terminal count: load wins, so no tick, no toggle and no digit advance.
- en=0:
  - counter, clk_out, digit_idx and digit_sel_n hold.
  - tick=0 and scan_wrap=0.
  - Counting resumes from the held counter value.
- Counter arithmetic is unsigned CNT_W bits. The counter never exceeds div_reg, because a load clears it, so no overflow case exists.
- Reset mid-count: immediate return to the reset values, and div_reg returns to DEFAULT_DIV (any loaded value is lost).

Decomposition:
- Shared package (display package): DIG_W derivation function (clog2), the DEFAULT_DIV constant for the 100 MHz board, and the N_DIGITS board constant.
- One sub-module: scan_ring.
  - Inputs: clk, rst, adv.
  - Outputs: digit_idx, digit_sel_n, scan_wrap.
  - Holds the digit counter and the one-hot decode.
- The divider core stays in the top level.

Test Plan:
1. Reset with DEFAULT_DIV=4, N_DIGITS=4 -> after rst release: tick, clk_out and scan_wrap are 0; digit_idx=0; digit_sel_n=4'b1110. First tick arrives 5 cycles after release.
2. Free run with DEFAULT_DIV=4 over 40 cycles -> tick every 5th cycle (8 pulses); clk_out period 10 cycles; digit_sel_n sequence 1101, 1011, 0111, 1110; scan_wrap pulses once per 20 cycles.
3. Pulse div_load with div_val=2 mid-count -> counter cleared; first tick 3 cycles later, then every 3 cycles. Pulse div_val=0 -> tick high every cycle and clk_out toggles every cycle.
4. Drive en=0 for 7 cycles at counter=2 -> no tick, outputs frozen. Set en=1 -> next tick after 3 more cycles, since counter continues from 2.
5. Assert div_load in the same cycle counter==div_reg -> no tick, no clk_out toggle, no digit advance; new period applies from 0.
6. Assert rst=0 asynchronously (between edges) while digit_idx=3 and clk_out=1 -> outputs return to reset values immediately, without waiting for a clk edge; div_reg reverts to DEFAULT_DIV.
